// File: rtl/regfile_scoreboard.sv
// Register file with a pending-write scoreboard: multi-port registered reads with
// write bypass, single writeback port, issue-time reservations and RAW stall detection.
module regfile_scoreboard #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic                stall,
  output logic [CW-1:0]       pend_cnt
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_next;
  logic [CW-1:0]   cnt_next;
  logic [NRP-1:0]  hazard;
  logic [AW-1:0]   addr   [NRP];
  logic [XLEN-1:0] rdata  [NRP];
  logic            busy_r [NRP];
  logic            wr_live;
  logic            rsv_live;

  // x0 is hardwired: writes and reservations targeting it are dropped here.
  assign wr_live  = wr_en && (wr_addr != '0);
  assign rsv_live = rsv_en && (rsv_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_port
      assign addr[gi]   = rd_addr[gi*AW +: AW];
      // An in-flight writeback to the same register resolves the hazard via bypass.
      assign hazard[gi] = rd_en[gi] && (addr[gi] != '0) && pending[addr[gi]]
                          && !(wr_en && (wr_addr == addr[gi]));
      assign rd_data[gi*XLEN +: XLEN] = rdata[gi];
      assign rd_busy[gi] = busy_r[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata[gi]  <= '0;
          busy_r[gi] <= 1'b0;
        end else if (rd_en[gi]) begin
          busy_r[gi] <= hazard[gi];
          if (addr[gi] == '0)
            rdata[gi] <= '0;
          else if (wr_en && (wr_addr == addr[gi]))
            rdata[gi] <= wr_data;
          else
            rdata[gi] <= mem[addr[gi]];
        end
      end
    end
  endgenerate

  assign stall = |hazard;

  // Flush beats reservation; reservation beats a same-cycle writeback clear.
  always_comb begin
    pend_next = pending;
    if (flush) begin
      pend_next = '0;
    end else begin
      if (wr_live)  pend_next[wr_addr]  = 1'b0;
      if (rsv_live) pend_next[rsv_addr] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < NREG; k++)
      cnt_next = cnt_next + CW'(pend_next[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++)
        mem[k] <= '0;
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard (XLEN=32, NREG=32, NRP=2),
// plus a hand-written mid-operation reset sequence.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic        stall;
  logic [5:0]  pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .NRP(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .stall(stall), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  ra;
    logic        fl;
    logic        x_stall;
    logic [31:0] x_d0;
    logic [31:0] x_d1;
    logic [1:0]  x_busy;
    logic [5:0]  x_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step%0d: got %0h, want %0h", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [4:0] ra, input logic fl);
    rd_en    = re;
    rd_addr  = {a1, a0};
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = rv;
    rsv_addr = ra;
    flush    = fl;
  endtask

  initial begin
    //          re     a0  a1  we  wa  wd            rv  ra  fl  stall d0            d1            busy   cnt
    tv[0]  = '{2'b00,  0,  0, 1,  5, 32'hDEADBEEF, 0,  0, 0,  0, 32'h0,        32'h0,        2'b00, 0};
    tv[1]  = '{2'b11,  5,  0, 0,  0, 32'h0,        0,  0, 0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 0};
    tv[2]  = '{2'b11,  7,  7, 1,  7, 32'h40,       0,  0, 0,  0, 32'h40,       32'h40,       2'b00, 0};
    tv[3]  = '{2'b11,  7,  5, 0,  0, 32'h0,        0,  0, 0,  0, 32'h40,       32'hDEADBEEF, 2'b00, 0};
    tv[4]  = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  3, 0,  0, 32'h40,       32'hDEADBEEF, 2'b00, 1};
    tv[5]  = '{2'b10,  0,  3, 0,  0, 32'h0,        0,  0, 0,  1, 32'h40,       32'h0,        2'b10, 1};
    tv[6]  = '{2'b10,  0,  3, 1,  3, 32'h20,       0,  0, 0,  0, 32'h40,       32'h20,       2'b00, 0};
    tv[7]  = '{2'b00,  0,  0, 1,  4, 32'h11,       1,  4, 0,  0, 32'h40,       32'h20,       2'b00, 1};
    tv[8]  = '{2'b01,  4,  0, 0,  0, 32'h0,        0,  0, 0,  1, 32'h11,       32'h20,       2'b01, 1};
    tv[9]  = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  1, 0,  0, 32'h11,       32'h20,       2'b01, 2};
    tv[10] = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  2, 0,  0, 32'h11,       32'h20,       2'b01, 3};
    tv[11] = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  3, 0,  0, 32'h11,       32'h20,       2'b01, 4};
    tv[12] = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  9, 1,  0, 32'h11,       32'h20,       2'b01, 0};
    tv[13] = '{2'b11,  9,  4, 0,  0, 32'h0,        0,  0, 0,  0, 32'h0,        32'h11,       2'b00, 0};
    tv[14] = '{2'b00,  0,  0, 1,  0, 32'hFFFF,     1,  0, 0,  0, 32'h0,        32'h11,       2'b00, 0};
    tv[15] = '{2'b11,  0,  0, 0,  0, 32'h0,        0,  0, 0,  0, 32'h0,        32'h0,        2'b00, 0};
    tv[16] = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  6, 0,  0, 32'h0,        32'h0,        2'b00, 1};
    tv[17] = '{2'b11,  6,  6, 1,  6, 32'h66,       0,  0, 0,  0, 32'h66,       32'h66,       2'b00, 0};
    tv[18] = '{2'b00,  0,  0, 0,  0, 32'h0,        1,  8, 0,  0, 32'h66,       32'h66,       2'b00, 1};
    tv[19] = '{2'b01,  8,  0, 0,  0, 32'h0,        1,  8, 0,  1, 32'h0,        32'h66,       2'b01, 1};
    tv[20] = '{2'b00,  0,  0, 1, 10, 32'hA,        0,  0, 0,  0, 32'h0,        32'h66,       2'b01, 1};
    tv[21] = '{2'b11, 10,  8, 1,  8, 32'h88,       0,  0, 1,  0, 32'hA,        32'h88,       2'b00, 0};

    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_rd_data", -1, rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("reset_busy", -1, {30'h0, rd_busy}, 32'h0);
    chk("reset_cnt", -1, {26'h0, pend_cnt}, 32'h0);
    chk("reset_stall", -1, {31'h0, stall}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].re, tv[i].a0, tv[i].a1, tv[i].we, tv[i].wa, tv[i].wd, tv[i].rv, tv[i].ra, tv[i].fl);
      #1;
      chk("stall", i, {31'h0, stall}, {31'h0, tv[i].x_stall});
      @(posedge clk);
      #1;
      chk("rd_data0", i, rd_data[31:0], tv[i].x_d0);
      chk("rd_data1", i, rd_data[63:32], tv[i].x_d1);
      chk("rd_busy", i, {30'h0, rd_busy}, {30'h0, tv[i].x_busy});
      chk("pend_cnt", i, {26'h0, pend_cnt}, {26'h0, tv[i].x_cnt});
      $display("[TB] step %0d: stall=%0b d0=%h d1=%h busy=%b cnt=%0d", i, tv[i].x_stall,
               rd_data[31:0], rd_data[63:32], rd_busy, pend_cnt);
    end

    // Reserve x5, then pulse reset between edges: outputs must clear without a clock edge.
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 1, 5, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_cnt", 100, {26'h0, pend_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 101, {26'h0, pend_cnt}, 32'd0);
    chk("async_rst_d0", 101, rd_data[31:0], 32'h0);
    chk("async_rst_d1", 101, rd_data[63:32], 32'h0);
    $display("[TB] async reset: cnt=%0d d0=%h d1=%h", pend_cnt, rd_data[31:0], rd_data[63:32]);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release operates normally; array contents were cleared by reset.
    @(negedge clk);
    drive(2'b11, 5, 7, 1, 5, 32'h55, 0, 0, 0);
    #1;
    chk("post_rst_stall", 102, {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_d0", 102, rd_data[31:0], 32'h55);
    chk("post_rst_d1", 102, rd_data[63:32], 32'h0);
    $display("[TB] post reset write/read: d0=%h d1=%h", rd_data[31:0], rd_data[63:32]);

    @(negedge clk);
    drive(2'b11, 10, 5, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_stall2", 103, {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_x10", 103, rd_data[31:0], 32'h0);
    chk("post_rst_x5", 103, rd_data[63:32], 32'h55);
    chk("post_rst_cnt", 103, {26'h0, pend_cnt}, 32'd0);
    $display("[TB] post reset read: d0=%h d1=%h cnt=%0d", rd_data[31:0], rd_data[63:32], pend_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
